dmem_arbiter: RTL

Two-requester arbiter and sequencer for the shared word-addressed data memory (4 KB window, 1024 x 32-bit words, synchronous write, combinational read). It accepts load/store requests from port A (core load/store unit) and port B (program loader / debug port) and serialises them onto the single memory port, fixed 2-cycle request-to-ack latency. It checks alignment and range, registers read data, and drives the memory enables so that read and write are never asserted together.

---
 rtl/dmem_arbiter.sv | 138 +++++++++++++
 1 files changed

// File: rtl/dmem_arbiter.sv
// Two-port arbiter/sequencer for a shared 1024x32 data memory.
// Every transaction takes IDLE -> ACCESS -> DONE, so request-to-ack latency is fixed at two cycles.
module dmem_arbiter #(
  parameter int ADDR_BITS  = 12,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [31:0] a_addr,
  input  logic [31:0] a_wdata,
  output logic        a_ack,
  output logic        a_err,
  output logic [31:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [31:0] b_addr,
  input  logic [31:0] b_wdata,
  output logic        b_ack,
  output logic        b_err,
  output logic [31:0] b_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr_en,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic [1:0]  state_dbg
);

  // Handshake: a requester raises x_req with x_we/x_addr/x_wdata stable and holds
  // them until the single-cycle x_ack; x_err/x_rdata are meaningful only with x_ack.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t      state, state_nxt;
  logic        last_grant;  // 0 = A, 1 = B
  logic        gnt_q;
  logic        we_q;
  logic        err_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q;

  logic        take;
  logic        grant_b;
  logic [31:0] sel_addr;
  logic        sel_err;

  // On a tie, round-robin hands the grant to whichever port did not win last.
  always_comb begin
    take     = a_req | b_req;
    grant_b  = b_req & (~a_req | (~FIXED_PRIO & ~last_grant));
    sel_addr = grant_b ? b_addr : a_addr;
    sel_err  = ((sel_addr >> ADDR_BITS) != 32'd0) | (sel_addr[1:0] != 2'b00);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (take) state_nxt = ACCESS;
      ACCESS:  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      gnt_q      <= 1'b0;
      we_q       <= 1'b0;
      err_q      <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rdata_q    <= 32'd0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (take) begin
            gnt_q   <= grant_b;
            we_q    <= grant_b ? b_we : a_we;
            addr_q  <= sel_addr;
            wdata_q <= grant_b ? b_wdata : a_wdata;
            err_q   <= sel_err;
          end
        end
        ACCESS:  rdata_q <= (we_q | err_q) ? 32'd0 : mem_rdata;
        DONE:    last_grant <= gnt_q;
        default: ;
      endcase
    end
  end

  // Enables are decoded from state alone, so an async reset in ACCESS kills a write at once.
  always_comb begin
    mem_addr  = 32'd0;
    mem_wdata = 32'd0;
    mem_wr_en = 1'b0;
    mem_rd_en = 1'b0;
    a_ack     = 1'b0;
    a_err     = 1'b0;
    a_rdata   = 32'd0;
    b_ack     = 1'b0;
    b_err     = 1'b0;
    b_rdata   = 32'd0;
    case (state)
      ACCESS: begin
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wr_en = we_q & ~err_q;
        mem_rd_en = ~we_q & ~err_q;
      end
      DONE: begin
        if (gnt_q) begin
          b_ack   = 1'b1;
          b_err   = err_q;
          b_rdata = rdata_q;
        end else begin
          a_ack   = 1'b1;
          a_err   = err_q;
          a_rdata = rdata_q;
        end
      end
      default: ;
    endcase
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
